// File: rtl/adc_pkg.sv
// adc_pkg
// Shared definitions for the PmodAD1 sampling front end: converter word
// width, conversion latency, sampler state encoding, and the helper that
// turns an offset-binary converter word into two's complement.
package adc_pkg;

  localparam int ADC_W   = 12;
  localparam int ADC_LAT = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CAPTURE,
    ST_DRAIN
  } smp_state_t;

  // Offset binary to two's complement: mid-scale (0x800) maps to zero.
  function automatic logic [ADC_W-1:0] offset_to_signed(input logic [ADC_W-1:0] raw);
    return {~raw[ADC_W-1], raw[ADC_W-2:0]};
  endfunction

endpackage

// File: rtl/adc_sample_timer.sv
// adc_sample_timer
// Sample-period counter. Holds a latched period (div clamped up to DIV_MIN)
// and produces the one-cycle ADC start pulse whenever the counter is at 0.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-low reset
//   active - counter runs while high, held at 0 while low
//   latch  - capture max(div, DIV_MIN) as the new period
//   div    - requested sample period in clk cycles
//   start  - high in every cycle where the running counter is 0
module adc_sample_timer
  import adc_pkg::*;
#(
  parameter int DIV_MIN = ADC_LAT + 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        active,
  input  logic        latch,
  input  logic [15:0] div,
  output logic        start
);

  localparam logic [15:0] DIV_MIN_W = 16'(DIV_MIN);

  logic [15:0] period;
  logic [15:0] cnt;

  // Period latch and free-running counter. The wrap test uses >= so that a
  // shorter period latched at a frame boundary cannot leave the counter
  // stranded above its new terminal value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period <= DIV_MIN_W;
      cnt    <= '0;
    end else begin
      if (latch) begin
        period <= (div < DIV_MIN_W) ? DIV_MIN_W : div;
      end
      if (!active) begin
        cnt <= '0;
      end else if (cnt >= period - 16'd1) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign start = active && (cnt == 16'd0);

endmodule

// File: rtl/adc_sampler.sv
// adc_sampler
// Sequencer for the dual-channel SPI ADC. Issues periodic start pulses,
// captures both channels once each conversion completes, converts them to
// two's complement and presents them on a valid/ready stream with a frame
// index and last-of-frame marker.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   en              - run enable
//   div             - sample period in clk cycles (clamped to DIV_MIN)
//   adc_start       - one-cycle trigger to the ADC interface
//   adc_d0, adc_d1  - converter words, offset binary
//   s_valid/s_ready - output stream handshake
//   s_ch0, s_ch1    - signed samples
//   s_idx, s_last   - position in frame, last-of-frame marker
//   overrun/ovr_clr - sticky lost-sample flag and its clear
module adc_sampler
  import adc_pkg::*;
#(
  parameter int FRAME_LEN = 1024,
  parameter int DIV_MIN   = ADC_LAT + 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [15:0]                  div,
  output logic                         adc_start,
  input  logic [ADC_W-1:0]             adc_d0,
  input  logic [ADC_W-1:0]             adc_d1,
  output logic                         s_valid,
  input  logic                         s_ready,
  output logic [ADC_W-1:0]             s_ch0,
  output logic [ADC_W-1:0]             s_ch1,
  output logic [$clog2(FRAME_LEN)-1:0] s_idx,
  output logic                         s_last,
  output logic                         overrun,
  input  logic                         ovr_clr
);

  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int CONV_W = $clog2(ADC_LAT + 2);
  localparam logic [CONV_W-1:0] CONV_PRE = CONV_W'(ADC_LAT);
  localparam logic [CONV_W-1:0] CONV_END = CONV_W'(ADC_LAT + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(FRAME_LEN - 1);

  smp_state_t        state;
  logic [CONV_W-1:0] conv_cnt;
  logic [IDX_W-1:0]  frame_idx;
  logic              timer_active;
  logic              capture_now;
  logic              period_latch;

  // The conversion counter reads k in the k-th cycle after a start, so the
  // converter result is taken when it reads ADC_LAT+1. Capture is keyed off
  // the counter rather than the state so an in-flight conversion still
  // lands while draining.
  assign timer_active = (state == ST_RUN) || (state == ST_CAPTURE);
  assign capture_now  = (conv_cnt == CONV_END);
  assign period_latch = ((state == ST_IDLE) && en) ||
                        (capture_now && (frame_idx == IDX_LAST));

  adc_sample_timer #(
    .DIV_MIN(DIV_MIN)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .active (timer_active),
    .latch  (period_latch),
    .div    (div),
    .start  (adc_start)
  );

  // Sequencer state, conversion counter and frame index. CAPTURE is entered
  // one cycle ahead so that it coincides with the capture cycle; DRAIN
  // waits until no conversion is outstanding before returning to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      conv_cnt  <= '0;
      frame_idx <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            state     <= ST_RUN;
            frame_idx <= '0;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state <= ST_DRAIN;
          end else if (conv_cnt == CONV_PRE) begin
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          state <= ST_RUN;
        end
        ST_DRAIN: begin
          if (conv_cnt == '0) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (adc_start) begin
        conv_cnt <= CONV_W'(1);
      end else if (capture_now) begin
        conv_cnt <= '0;
      end else if (conv_cnt != '0) begin
        conv_cnt <= conv_cnt + CONV_W'(1);
      end

      if (capture_now) begin
        frame_idx <= frame_idx + IDX_W'(1);
      end
    end
  end

  // Output register and handshake. A capture always loads, even over an
  // unaccepted sample, so frame timing is preserved; the loss is recorded
  // in the sticky overrun flag, whose set beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_valid <= 1'b0;
      s_ch0   <= '0;
      s_ch1   <= '0;
      s_idx   <= '0;
      s_last  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (capture_now) begin
        s_ch0   <= offset_to_signed(adc_d0);
        s_ch1   <= offset_to_signed(adc_d1);
        s_idx   <= frame_idx;
        s_last  <= (frame_idx == IDX_LAST);
        s_valid <= 1'b1;
      end else if (s_valid && s_ready) begin
        s_valid <= 1'b0;
      end

      if (capture_now && s_valid && !s_ready) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler
// Scoreboard bench for adc_sampler with a short frame. An ADC model answers
// each start pulse with the next entry of a hand-computed vector table and
// pushes the expected signed words, index and last flag; a monitor pops and
// compares on every transfer and also checks start spacing and latency.
module tb_adc_sampler;
  import adc_pkg::*;

  localparam int FL    = 4;
  localparam int IDX_W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [15:0]      div;
  logic             adc_start;
  logic [11:0]      adc_d0 = '0;
  logic [11:0]      adc_d1 = '0;
  logic             s_valid;
  logic             s_ready;
  logic [11:0]      s_ch0;
  logic [11:0]      s_ch1;
  logic [IDX_W-1:0] s_idx;
  logic             s_last;
  logic             overrun;
  logic             ovr_clr;

  adc_sampler #(
    .FRAME_LEN(FL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div       (div),
    .adc_start (adc_start),
    .adc_d0    (adc_d0),
    .adc_d1    (adc_d1),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_ch0     (s_ch0),
    .s_ch1     (s_ch1),
    .s_idx     (s_idx),
    .s_last    (s_last),
    .overrun   (overrun),
    .ovr_clr   (ovr_clr)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0]      ch0;
    logic [11:0]      ch1;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  // Converter words and their hand-computed two's complement images.
  logic [11:0] vec_d0 [16] = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006, 12'h007,
                               12'hFFF, 12'h800, 12'h00A, 12'h00B, 12'h00C, 12'h00D, 12'h00E, 12'h00F};
  logic [11:0] vec_d1 [16] = '{12'hFFF, 12'h800, 12'h7FF, 12'h123, 12'hABC, 12'h456, 12'h7FE, 12'h801,
                               12'h000, 12'h555, 12'h0AA, 12'hF0F, 12'h3C3, 12'hC3C, 12'h100, 12'hEEE};
  logic [11:0] exp_c0 [16] = '{12'h800, 12'h801, 12'h802, 12'h803, 12'h804, 12'h805, 12'h806, 12'h807,
                               12'h7FF, 12'h000, 12'h80A, 12'h80B, 12'h80C, 12'h80D, 12'h80E, 12'h80F};
  logic [11:0] exp_c1 [16] = '{12'h7FF, 12'h000, 12'hFFF, 12'h923, 12'h2BC, 12'hC56, 12'hFFE, 12'h001,
                               12'h800, 12'hD55, 12'h8AA, 12'h70F, 12'hBC3, 12'h43C, 12'h900, 12'h6EE};

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pend = 0;
  int   vec_k = 0;
  int   sb_idx = 0;
  int   n_prod = 0;
  int   n_xfer = 0;
  int   starts = 0;
  int   last_start = 0;
  int   have_last = 0;
  int   exp_period = 0;
  logic valid_q = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_adc_start"}, 32'(adc_start), 0);
    checkOutput({tag, "_s_valid"}, 32'(s_valid), 0);
    checkOutput({tag, "_s_last"}, 32'(s_last), 0);
    checkOutput({tag, "_overrun"}, 32'(overrun), 0);
    checkOutput({tag, "_s_ch0"}, 32'(s_ch0), 0);
    checkOutput({tag, "_s_ch1"}, 32'(s_ch1), 0);
    checkOutput({tag, "_s_idx"}, 32'(s_idx), 0);
  endtask

  task automatic applyStimulus(input logic e, input logic [15:0] d, input logic r, input logic c);
    en      = e;
    div     = d;
    s_ready = r;
    ovr_clr = c;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitSamples(input int n, input int budget, input string name);
    int target = n_xfer + n;
    int t = 0;
    while (n_xfer < target && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    checkOutput(name, 32'(n_xfer >= target), 1);
  endtask

  task automatic waitStart(input int budget, input string name);
    int s0 = starts;
    int t = 0;
    while (starts == s0 && t < budget) begin
      @(posedge clk);
      t++;
    end
    #1;
    checkOutput(name, 32'(starts > s0), 1);
  endtask

  // ADC model plus monitor, evaluated on the falling edge. The model answers
  // a start seen at cycle t0 by updating its words ADC_LAT cycles later.
  task automatic scoreboardLoop();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        pend = 0;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          adc_d0 = vec_d0[vec_k % 16];
          adc_d1 = vec_d1[vec_k % 16];
          e.ch0  = exp_c0[vec_k % 16];
          e.ch1  = exp_c1[vec_k % 16];
          e.idx  = IDX_W'(sb_idx);
          e.last = (sb_idx == FL - 1);
          sb_q.push_back(e);
          sb_idx = (sb_idx + 1) % FL;
          vec_k++;
          n_prod++;
        end
      end
      if (adc_start) begin
        starts++;
        if (have_last != 0) checkOutput("start_spacing", 32'(cyc - last_start), 32'(exp_period));
        last_start = cyc;
        have_last  = 1;
        pend       = ADC_LAT;
      end
      if (s_valid && !valid_q) checkOutput("start_to_valid", 32'(cyc - last_start), ADC_LAT + 2);
      valid_q = s_valid;
      if (s_valid && s_ready) begin
        n_xfer++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_sample: got idx %0d expected none", s_idx);
        end else begin
          e = sb_q.pop_front();
          checkOutput("s_ch0", 32'(s_ch0), 32'(e.ch0));
          checkOutput("s_ch1", 32'(s_ch1), 32'(e.ch1));
          checkOutput("s_idx", 32'(s_idx), 32'(e.idx));
          checkOutput("s_last", 32'(s_last), 32'(e.last));
        end
      end
    end
  endtask

  initial begin
    int s0;
    int x0;
    int p0;
    int t;
    fork
      scoreboardLoop();
    join_none

    rst = 1'b0;
    applyStimulus(1'b0, 16'd2268, 1'b1, 1'b0);
    waitCycles(3);
    checkReset("reset");
    rst = 1'b1;
    waitCycles(2);

    // Nominal rate: six samples wrap the four-entry frame.
    $display("[TB] nominal period 2268");
    exp_period = 2268;
    have_last  = 0;
    sb_idx     = 0;
    applyStimulus(1'b1, 16'd2268, 1'b1, 1'b0);
    waitSamples(6, 6 * 2268 + 1000, "timeout_nominal");

    // Drop enable mid-conversion: one last sample, then silence.
    $display("[TB] drain");
    waitStart(3000, "timeout_drain_start");
    waitCycles(20);
    applyStimulus(1'b0, 16'd2268, 1'b1, 1'b0);
    s0 = starts;
    x0 = n_xfer;
    waitCycles(400);
    checkOutput("drain_no_start", 32'(starts), 32'(s0));
    checkOutput("drain_one_sample", 32'(n_xfer), 32'(x0 + 1));

    // Too-short period clamps; restart begins a fresh frame at index 0.
    $display("[TB] clamped period");
    exp_period = 131;
    have_last  = 0;
    sb_idx     = 0;
    applyStimulus(1'b1, 16'd10, 1'b1, 1'b0);
    waitSamples(5, 5 * 131 + 400, "timeout_clamp");

    // Two captures with no acceptance: first one is lost.
    $display("[TB] overrun");
    applyStimulus(1'b1, 16'd10, 1'b0, 1'b0);
    p0 = n_prod;
    t  = 0;
    while (n_prod < p0 + 2 && t < 600) begin
      @(posedge clk);
      t++;
    end
    checkOutput("timeout_overrun", 32'(n_prod >= p0 + 2), 1);
    waitCycles(3);
    checkOutput("overrun_set", 32'(overrun), 1);
    checkOutput("valid_held", 32'(s_valid), 1);
    if (sb_q.size() > 0) void'(sb_q.pop_front());
    applyStimulus(1'b1, 16'd10, 1'b1, 1'b0);
    waitCycles(4);
    checkOutput("overrun_sticky", 32'(overrun), 1);
    applyStimulus(1'b1, 16'd10, 1'b1, 1'b1);
    waitCycles(1);
    applyStimulus(1'b1, 16'd10, 1'b1, 1'b0);
    checkOutput("overrun_clr", 32'(overrun), 0);

    // Asynchronous reset in the middle of a conversion.
    $display("[TB] async reset");
    waitStart(400, "timeout_rst_start");
    waitCycles(30);
    #2;
    rst = 1'b0;
    #1;
    checkReset("async_rst");
    en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    s0  = starts;
    x0  = n_xfer;
    waitCycles(300);
    checkOutput("post_rst_no_valid", 32'(n_xfer), 32'(x0));
    checkOutput("post_rst_no_start", 32'(starts), 32'(s0));
    have_last = 0;
    sb_idx    = 0;
    applyStimulus(1'b1, 16'd10, 1'b1, 1'b0);
    waitSamples(2, 2 * 131 + 400, "timeout_restart");
    checkOutput("queue_empty", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
